// File: rtl/serial_shift_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : serial_shift_ctrl                                              |
// | Brief    : Multi-cycle register-amount ARM shifter, one bit per clock.    |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
module serial_shift_ctrl #(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        shift_type,
  input  logic              rrx,
  input  logic [AMT_W-1:0]  amount,
  input  logic [DATA_W-1:0] Val_Rm,
  input  logic              carry_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] Val_2,
  output logic              carry_out
);

  localparam int CNT_W = $clog2(DATA_W + 2);
  localparam int EXT_W = ((AMT_W > CNT_W) ? AMT_W : CNT_W) + 1;

  localparam logic [1:0] c_LSL = 2'b00;
  localparam logic [1:0] c_LSR = 2'b01;
  localparam logic [1:0] c_ASR = 2'b10;
  localparam logic [1:0] c_ROR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_type;
  logic              r_rrx;
  logic              w_accept;
  logic [EXT_W-1:0]  w_amt_ext;
  logic [EXT_W-1:0]  w_ror_mod;
  logic [CNT_W-1:0]  w_n;
  logic [DATA_W-1:0] w_step_v;
  logic              w_step_c;

  assign w_accept  = start && (r_state != S_SHIFT);
  assign w_amt_ext = EXT_W'(amount);
  assign w_ror_mod = w_amt_ext & EXT_W'(DATA_W - 1);

  // Step count: the clamps make the ARM out-of-range results fall out naturally
  always_comb begin
    w_n = '0;
    if (rrx) begin
      w_n = CNT_W'(1);
    end else if (amount != '0) begin
      case (shift_type)
        c_LSL, c_LSR: w_n = (w_amt_ext > EXT_W'(DATA_W + 1)) ? CNT_W'(DATA_W + 1) : CNT_W'(w_amt_ext);
        c_ASR:        w_n = (w_amt_ext > EXT_W'(DATA_W))     ? CNT_W'(DATA_W)     : CNT_W'(w_amt_ext);
        default:      w_n = (w_ror_mod == '0)                ? CNT_W'(DATA_W)     : CNT_W'(w_ror_mod);
      endcase
    end
  end

  always_comb begin
    w_step_c = Val_2[0];
    w_step_v = {1'b0, Val_2[DATA_W-1:1]};
    if (r_rrx) begin
      w_step_v = {carry_out, Val_2[DATA_W-1:1]};
    end else begin
      case (r_type)
        c_LSL: begin
          w_step_c = Val_2[DATA_W-1];
          w_step_v = {Val_2[DATA_W-2:0], 1'b0};
        end
        c_LSR:   w_step_v = {1'b0, Val_2[DATA_W-1:1]};
        c_ASR:   w_step_v = {Val_2[DATA_W-1], Val_2[DATA_W-1:1]};
        default: w_step_v = {Val_2[0], Val_2[DATA_W-1:1]};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    busy         = (r_state != S_IDLE);
    done         = (r_state == S_DONE);
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_next_state = (w_n == '0) ? S_DONE : S_SHIFT;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_next_state = S_DONE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_type    <= c_LSL;
      r_rrx     <= 1'b0;
      Val_2     <= '0;
      carry_out <= 1'b0;
    end else if (w_accept) begin
      r_cnt     <= w_n;
      r_type    <= shift_type;
      r_rrx     <= rrx;
      Val_2     <= Val_Rm;
      carry_out <= carry_in;
    end else if (r_state == S_SHIFT) begin
      r_cnt     <= r_cnt - CNT_W'(1);
      Val_2     <= w_step_v;
      carry_out <= w_step_c;
    end
  end

endmodule
`default_nettype wire
